// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) line arbiter in front of a single-ported memory.
// Optional MEM_ARB_RR_EN selects round-robin instead of fixed D-over-I priority.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        ic_req,
   input  logic [13:0] ic_addr,
   input  logic        dc_req,
   input  logic        dc_we,
   input  logic [13:0] dc_addr,
   input  logic [63:0] dc_wdata,
   output logic        ic_done,
   output logic        dc_done,
   output logic [63:0] rdata,
   output logic        busy,
   output logic        mem_re,
   output logic        mem_we,
   output logic [13:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rd_data,
   input  logic        mem_rdy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t state;
   logic   grant_dc;
   logic   op_we;
   logic   pick_dc;

`ifdef MEM_ARB_RR_EN
   // last_dc remembers which port completed most recently; a tie goes to the other one
   logic last_dc;

   always_comb pick_dc = dc_req && !(ic_req && last_dc);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_dc <= 1'b1;
      end else if (state == DONE) begin
         last_dc <= grant_dc;
      end
   end
`else
   always_comb pick_dc = dc_req;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_dc  <= 1'b0;
         op_we     <= 1'b0;
         ic_done   <= 1'b0;
         dc_done   <= 1'b0;
         busy      <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         rdata     <= 64'd0;
         mem_addr  <= 14'd0;
         mem_wdata <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (ic_req || dc_req) begin
                  grant_dc <= pick_dc;
                  op_we    <= pick_dc && dc_we;
                  mem_re   <= !(pick_dc && dc_we);
                  mem_we   <= pick_dc && dc_we;
                  mem_addr <= pick_dc ? dc_addr : ic_addr;
                  if (pick_dc) begin
                     mem_wdata <= dc_wdata;
                  end
                  busy  <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               // strobes last one cycle; mem_rdy is not looked at here
               mem_re <= 1'b0;
               mem_we <= 1'b0;
               state  <= WAIT;
            end
            WAIT: begin
               if (mem_rdy) begin
                  if (!op_we) begin
                     rdata <= mem_rd_data;
                  end
                  ic_done <= !grant_dc;
                  dc_done <= grant_dc;
                  state   <= DONE;
               end
            end
            DONE: begin
               ic_done <= 1'b0;
               dc_done <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-003 ic_req  input  1  I-cache fill request; level, held until ic_done.
REQ-004 ic_addr  input  14  I-cache line address (64-bit line index).
REQ-005 dc_req  input  1  D-cache request; level, held until dc_done.
REQ-006 dc_we  input  1  D-cache op type: 1 = line write (evict), 0 = line read (fill).
REQ-007 dc_addr  input  14  D-cache line address.
REQ-008 dc_wdata  input  64  D-cache write line.
REQ-009 ic_done / dc_done  output  1 each  one-cycle completion pulse to the granted requester.
REQ-010 rdata  output  64  registered read line; valid in the done cycle.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 mem_re / mem_we  output  1 each  memory strobes.
REQ-013 mem_addr  output  14  memory line address.
REQ-014 mem_wdata  output  64  memory write line.
REQ-015 mem_rd_data  input  64  memory read line.
REQ-016 mem_rdy  input  1  memory ready; low while an access is in progress, high in the access's final cycle.

Function
REQ-017 The block SHALL use states IDLE, ISSUE, WAIT and DONE; encoding is free.
REQ-018 IDLE: if any req is high, the block SHALL latch the winner, its op and its addr/wdata, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 ISSUE: the block SHALL assert exactly one of mem_re/mem_we for exactly this one cycle, then go to WAIT.
REQ-020 mem_addr and mem_wdata SHALL come from the latched copies and SHALL stay stable from ISSUE through the WAIT exit edge.
REQ-021 WAIT: mem_rdy SHALL be ignored in the ISSUE cycle. On the first edge in WAIT with mem_rdy=1, the block SHALL register mem_rd_data into rdata (reads only) and go to DONE.
REQ-022 DONE: the block SHALL pulse the granted requester's done for one cycle, then go to IDLE.
REQ-023 Requests SHALL be sampled only in IDLE. A requester that holds req past its done is re-arbitrated as a new request.
REQ-024 Default arbitration: fixed priority, dc_req over ic_req.
REQ-025 A req that falls during ISSUE or WAIT SHALL NOT abort the access; the access completes and done still pulses.
REQ-026 For a 4-cycle memory, latency SHALL be: req seen at edge T -> ISSUE T+1 -> mem_rdy high in cycle T+5 -> done and rdata in cycle T+6. Back-to-back grants SHALL be separated by one IDLE cycle.
REQ-027 ic requests are always reads. For writes, rdata SHALL hold its previous value.
REQ-028 mem_re and mem_we SHALL never be high together, and neither SHALL be high outside ISSUE.

Reset
REQ-029 With rst high at a clock edge: state = IDLE; ic_done, dc_done, busy, mem_re, mem_we = 0; rdata, mem_addr, mem_wdata = 0; round-robin pointer = D-cache last.
REQ-030 A reset during ISSUE, WAIT or DONE SHALL abandon the access with no done pulse. The memory's active-low reset SHALL be driven from the same system reset so both blocks return to idle together.

Configuration
REQ-031 Macro MEM_ARB_RR_EN:
- Defined: round-robin between ports. On simultaneous requests, the port not granted last wins. The pointer updates in DONE.
- Undefined: fixed D-over-I priority; no pointer logic is built.

Verification
REQ-032 Single I-fill: ic_req, ic_addr=0x0010, memory holds 0x1111_2222_3333_4444 -> one mem_re at T+1 with mem_addr=0x0010; ic_done and rdata=0x1111_2222_3333_4444 at T+6.
REQ-033 D-evict: dc_we=1, dc_addr=0x3FFF, dc_wdata=0xDEAD_BEEF_0123_4567 -> one mem_we; read-back of 0x3FFF returns the same value; rdata unchanged.
REQ-034 Simultaneous ic_req and dc_req held for two grants:
- without MEM_ARB_RR_EN: dc served first, then ic;
- with MEM_ARB_RR_EN: after a dc grant, the next tie goes to ic, then dc.
REQ-035 Starvation check without the macro: dc_req re-raised immediately after each dc_done for 3 grants -> ic waits all 3; ic is served when dc goes idle.
REQ-036 Reset mid-WAIT: rst pulsed at T+3 of a read -> no done; busy=0 next cycle; a new ic request afterwards completes normally.
REQ-037 Req dropped in WAIT: dc_req falls at T+2 -> dc_done still pulses at T+6; no further mem strobes.
